// File: rtl/bch_correct_buffer.sv
// bch_correct_buffer
// Receive-side correction buffer for the BCH decoder chain. Data words of
// each received codeword are parked in a data RAM while the syndrome,
// key-solver and Chien stages run. The error-location words from the Chien
// stream are parked in a mask RAM. Once a frame's mask is complete, the
// frame is read out as data XOR mask. Frames leave in arrival order on a
// stallable word stream.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   in_valid/in_first/in_data     received data words, in_ready = accept
//   err_valid/err_first/err_last  error mask words (never stalled)
//   err
//   out_valid/out_first/out_last  corrected word stream, out_ready = accept
//   out_data
//   proto_err                     sticky protocol-violation flag
module bch_correct_buffer #(
   parameter int DATA_BITS = 256,
   parameter int BITS      = 32,
   parameter int FRAMES    = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            in_first,
   input  logic [BITS-1:0] in_data,
   output logic            in_ready,
   input  logic            err_valid,
   input  logic            err_first,
   input  logic            err_last,
   input  logic [BITS-1:0] err,
   output logic            out_valid,
   output logic            out_first,
   output logic            out_last,
   output logic [BITS-1:0] out_data,
   input  logic            out_ready,
   output logic            proto_err
);
   localparam int W     = DATA_BITS / BITS;
   localparam int IW    = (W > 1) ? $clog2(W) : 1;
   localparam int PW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
   localparam int CW    = $clog2(FRAMES + 1);
   localparam int DEPTH = FRAMES * W;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(FRAMES - 1);
   localparam logic [CW-1:0] FRAMES_C  = CW'(FRAMES);
   localparam logic [AW-1:0] W_A       = AW'(W);

   typedef enum logic [0:0] {D_IDLE = 1'b0, D_FILL = 1'b1} d_state_t;
   typedef enum logic [0:0] {E_IDLE = 1'b0, E_FILL = 1'b1} e_state_t;

   function automatic logic [PW-1:0] next_slot_f(input logic [PW-1:0] s);
      if (s == LAST_SLOT) return {PW{1'b0}};
      else                return s + PW'(1);
   endfunction

   function automatic logic [AW-1:0] addr_f(input logic [PW-1:0] s, input logic [IW-1:0] i);
      return AW'(s) * W_A + AW'(i);
   endfunction

   logic [BITS-1:0] data_mem_r [DEPTH];
   logic [BITS-1:0] mask_mem_r [DEPTH];

   // data writer
   d_state_t        d_state_r, d_state_s;
   logic [PW-1:0]   d_slot_r, d_slot_s;
   logic [IW-1:0]   d_idx_r, d_idx_s, d_widx_s;
   logic [CW-1:0]   alloc_cnt_r, alloc_cnt_s;
   logic            in_ready_r, d_acc_s, d_we_s, d_done_s, d_alloc_s, d_proto_s;
   // error writer
   e_state_t        e_state_r, e_state_s;
   logic [PW-1:0]   m_slot_r, m_slot_s;
   logic [IW-1:0]   e_idx_r, e_idx_s, e_widx_s;
   logic [CW-1:0]   dm_gap_r, ready_cnt_r;
   logic            e_take_s, e_done_s, e_proto_s;
   // reader, read stage and output skid
   logic [PW-1:0]   r_slot_r;
   logic [IW-1:0]   r_idx_r;
   logic [AW-1:0]   rd_addr_s;
   logic [1:0]      occ_s, sk_cnt_r;
   logic            pop_s, credit_s, rd_go_s, rd_end_s, free_s;
   logic            rd_vld_r, rd_first_r, rd_last_r;
   logic [BITS-1:0] rd_data_r;
   logic            out_valid_r, out_first_r, out_last_r, sp_first_r, sp_last_r;
   logic [BITS-1:0] out_data_r, sp_data_r;
   logic            proto_r;

   // Data writer: places words, allocates a slot on word 0, flags data-complete at W-1
   always_comb begin
      d_state_s = d_state_r;
      d_slot_s  = d_slot_r;
      d_idx_s   = d_idx_r;
      d_we_s    = 1'b0;
      d_done_s  = 1'b0;
      d_alloc_s = 1'b0;
      d_proto_s = 1'b0;
      d_acc_s   = in_valid & in_ready_r;
      if (in_first) d_widx_s = {IW{1'b0}};
      else          d_widx_s = d_idx_r;
      case (d_state_r)
         D_IDLE: begin
            if (d_acc_s && in_first) begin
               d_we_s    = 1'b1;
               d_alloc_s = 1'b1;
            end else begin
               d_proto_s = d_acc_s;
            end
         end
         D_FILL: begin
            if (d_acc_s) begin
               d_we_s    = 1'b1;
               d_proto_s = in_first;   // restart of the current slot
            end else begin
               d_we_s = 1'b0;
            end
         end
         default: d_state_s = D_IDLE;
      endcase
      if (d_we_s && (d_widx_s == LAST_IDX)) begin
         d_done_s  = 1'b1;
         d_state_s = D_IDLE;
         d_idx_s   = {IW{1'b0}};
         d_slot_s  = next_slot_f(d_slot_r);
      end else if (d_we_s) begin
         d_state_s = D_FILL;
         d_idx_s   = d_widx_s + IW'(1);
      end else begin
         d_idx_s = d_idx_r;
      end
   end

   // Error writer: err_first is legal only against a frame whose data completed earlier
   always_comb begin
      e_state_s = e_state_r;
      m_slot_s  = m_slot_r;
      e_idx_s   = e_idx_r;
      e_take_s  = 1'b0;
      e_done_s  = 1'b0;
      e_proto_s = 1'b0;
      if (err_first) e_widx_s = {IW{1'b0}};
      else           e_widx_s = e_idx_r;
      case (e_state_r)
         E_IDLE: begin
            if (err_valid && err_first && (dm_gap_r != {CW{1'b0}})) begin
               e_take_s = 1'b1;
            end else begin
               e_proto_s = err_valid & err_first;
            end
         end
         E_FILL: begin
            if (err_valid) begin
               e_take_s  = 1'b1;
               e_proto_s = err_first;
            end else begin
               e_take_s = 1'b0;
            end
         end
         default: e_state_s = E_IDLE;
      endcase
      if (e_take_s && (e_widx_s == LAST_IDX)) begin
         e_state_s = E_IDLE;
         e_idx_s   = {IW{1'b0}};
         if (err_last) begin
            e_done_s = 1'b1;
            m_slot_s = next_slot_f(m_slot_r);
         end else begin
            e_proto_s = 1'b1;   // frame abandoned, slot stays for a retry
         end
      end else if (e_take_s && err_last) begin
         e_proto_s = 1'b1;
         e_state_s = E_IDLE;
         e_idx_s   = {IW{1'b0}};
      end else if (e_take_s) begin
         e_state_s = E_FILL;
         e_idx_s   = e_widx_s + IW'(1);
      end else begin
         e_idx_s = e_idx_r;
      end
   end

   // Reader: issue a read whenever a mask-complete frame waits and the skid has room
   always_comb begin
      pop_s  = out_valid_r & out_ready;
      free_s = pop_s & out_last_r;
      occ_s  = sk_cnt_r + {1'b0, rd_vld_r};
      if (pop_s) credit_s = (occ_s < 2'd3);
      else       credit_s = (occ_s < 2'd2);
      rd_go_s     = (ready_cnt_r != {CW{1'b0}}) & credit_s;
      rd_end_s    = rd_go_s & (r_idx_r == LAST_IDX);
      rd_addr_s   = addr_f(r_slot_r, r_idx_r);
      alloc_cnt_s = alloc_cnt_r + CW'(d_alloc_s) - CW'(free_s);
   end

   // Control registers for both writers, the reader and the protocol flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_state_r   <= D_IDLE;
         d_slot_r    <= {PW{1'b0}};
         d_idx_r     <= {IW{1'b0}};
         alloc_cnt_r <= {CW{1'b0}};
         in_ready_r  <= 1'b0;
         e_state_r   <= E_IDLE;
         m_slot_r    <= {PW{1'b0}};
         e_idx_r     <= {IW{1'b0}};
         dm_gap_r    <= {CW{1'b0}};
         ready_cnt_r <= {CW{1'b0}};
         r_slot_r    <= {PW{1'b0}};
         r_idx_r     <= {IW{1'b0}};
         rd_vld_r    <= 1'b0;
         rd_first_r  <= 1'b0;
         rd_last_r   <= 1'b0;
         proto_r     <= 1'b0;
      end else begin
         d_state_r   <= d_state_s;
         d_slot_r    <= d_slot_s;
         d_idx_r     <= d_idx_s;
         alloc_cnt_r <= alloc_cnt_s;
         // registered so a freed slot shows one cycle later and out_ready never reaches in_ready
         in_ready_r  <= (alloc_cnt_s < FRAMES_C) | (d_state_s == D_FILL);
         e_state_r   <= e_state_s;
         m_slot_r    <= m_slot_s;
         e_idx_r     <= e_idx_s;
         dm_gap_r    <= dm_gap_r + CW'(d_done_s) - CW'(e_done_s);
         ready_cnt_r <= ready_cnt_r + CW'(e_done_s) - CW'(rd_end_s);
         if (rd_end_s) begin
            r_idx_r  <= {IW{1'b0}};
            r_slot_r <= next_slot_f(r_slot_r);
         end else if (rd_go_s) begin
            r_idx_r  <= r_idx_r + IW'(1);
         end
         rd_vld_r   <= rd_go_s;
         rd_first_r <= (r_idx_r == {IW{1'b0}});
         rd_last_r  <= (r_idx_r == LAST_IDX);
         proto_r    <= proto_r | d_proto_s | e_proto_s;
      end
   end

   // Data and mask RAMs with a registered, already-corrected read port
   always_ff @(posedge clk) begin
      if (d_we_s) data_mem_r[addr_f(d_slot_r, d_widx_s)] <= in_data;
      if (e_take_s) mask_mem_r[addr_f(m_slot_r, e_widx_s)] <= err;
      if (rd_go_s) rd_data_r <= data_mem_r[rd_addr_s] ^ mask_mem_r[rd_addr_s];
   end

   // Two-entry output skid: head drives the outputs, spare absorbs one word of stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sk_cnt_r    <= 2'd0;
         out_valid_r <= 1'b0;
         out_first_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= {BITS{1'b0}};
         sp_first_r  <= 1'b0;
         sp_last_r   <= 1'b0;
         sp_data_r   <= {BITS{1'b0}};
      end else begin
         case (sk_cnt_r)
            2'd0: begin
               if (rd_vld_r) begin
                  {out_first_r, out_last_r, out_data_r} <= {rd_first_r, rd_last_r, rd_data_r};
                  out_valid_r <= 1'b1;
                  sk_cnt_r    <= 2'd1;
               end
            end
            2'd1: begin
               if (rd_vld_r && pop_s) begin
                  {out_first_r, out_last_r, out_data_r} <= {rd_first_r, rd_last_r, rd_data_r};
               end else if (rd_vld_r) begin
                  {sp_first_r, sp_last_r, sp_data_r} <= {rd_first_r, rd_last_r, rd_data_r};
                  sk_cnt_r <= 2'd2;
               end else if (pop_s) begin
                  out_valid_r <= 1'b0;
                  sk_cnt_r    <= 2'd0;
               end
            end
            2'd2: begin
               if (pop_s) begin
                  {out_first_r, out_last_r, out_data_r} <= {sp_first_r, sp_last_r, sp_data_r};
                  if (rd_vld_r) begin
                     {sp_first_r, sp_last_r, sp_data_r} <= {rd_first_r, rd_last_r, rd_data_r};
                  end else begin
                     sk_cnt_r <= 2'd1;
                  end
               end
            end
            default: begin
               sk_cnt_r    <= 2'd0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_first = out_first_r;
   assign out_last  = out_last_r;
   assign out_data  = out_data_r;
   assign proto_err = proto_r;

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Self-checking bench for bch_correct_buffer (default parameters, W = 8).
// Stimulus tasks push expected corrected words (data XOR mask, with first/last
// flags) into a scoreboard queue; an independent monitor pops and compares
// every accepted output word and checks that outputs hold while stalled.
`timescale 1ns/1ps
module tb_bch_correct_buffer;
   localparam int W = 8;
   typedef logic [31:0] frame_t [W];

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_first, in_ready;
   logic [31:0] in_data;
   logic        err_valid, err_first, err_last;
   logic [31:0] err;
   logic        out_valid, out_first, out_last, out_ready, proto_err;
   logic [31:0] out_data;

   always #5 clk = ~clk;

   bch_correct_buffer #(.DATA_BITS(256), .BITS(32), .FRAMES(2)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_first(in_first), .in_data(in_data), .in_ready(in_ready),
      .err_valid(err_valid), .err_first(err_first), .err_last(err_last), .err(err),
      .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
      .out_data(out_data), .out_ready(out_ready), .proto_err(proto_err)
   );

   int          checks = 0;
   int          failures = 0;
   int          out_count = 0;
   bit          ready_rand = 1'b0;
   logic [33:0] exp_q [$];   // {first, last, data}
   logic [31:0] pend_q [$];  // data words of data-complete frames still awaiting a mask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // downstream ready: either always on or a 50% coin flip each cycle
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (ready_rand) out_ready = ($urandom_range(0, 1) == 1);
         else            out_ready = 1'b1;
      end
   end

   // monitor: compare accepted words with the scoreboard and check stall stability
   initial begin
      logic        hold_v;
      logic [33:0] hold_w, got;
      hold_v = 1'b0;
      hold_w = 34'h0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_v = 1'b0;
         end else begin
            got = {out_first, out_last, out_data};
            if (hold_v) check("stall_hold", {29'h0, out_valid, got}, {29'h0, 1'b1, hold_w});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out: got 0x%0h with empty scoreboard", got);
               end else begin
                  check("out_word", {30'h0, got}, {30'h0, exp_q.pop_front()});
               end
               out_count++;
               hold_v = 1'b0;
            end else if (out_valid) begin
               hold_v = 1'b1;
               hold_w = got;
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   task automatic send_data(input frame_t f);
      int n;
      bit acc;
      for (int k = 0; k < W; k++) begin
         in_valid = 1'b1;
         in_first = (k == 0);
         in_data  = f[k];
         n   = 0;
         acc = 1'b0;
         while (!acc && n < 400) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
         end
         if (!acc) fail_now("in_ready_timeout");
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      for (int k = 0; k < W; k++) pend_q.push_back(f[k]);
   endtask

   // mask stream; legal only when a data-complete frame is waiting for its mask
   task automatic send_err(input frame_t m);
      bit legal;
      legal = (pend_q.size() >= W);
      for (int k = 0; k < W; k++) begin
         err_valid = 1'b1;
         err_first = (k == 0);
         err_last  = (k == W - 1);
         err       = m[k];
         @(posedge clk); #1;
         if (!legal && k == 0) check("proto_set", proto_err, 1);
      end
      err_valid = 1'b0;
      err_first = 1'b0;
      err_last  = 1'b0;
      if (legal) begin
         for (int k = 0; k < W; k++) begin
            exp_q.push_back({(k == 0), (k == W - 1), pend_q.pop_front() ^ m[k]});
         end
      end
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail_now("drain_timeout");
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f, m;
      int     n, c0;
      bit     seen;

      reset = 1'b1;
      in_valid = 1'b0; in_first = 1'b0; in_data = 32'h0;
      err_valid = 1'b0; err_first = 1'b0; err_last = 1'b0; err = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_proto", proto_err, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("in_ready_before_edge", in_ready, 0);
      @(posedge clk); #1;
      check("in_ready_after_rst", in_ready, 1);

      // single frame, one flipped bit in word 3
      for (int k = 0; k < W; k++) begin f[k] = k; m[k] = 32'h0; end
      m[3] = 32'h1;
      send_data(f);
      send_err(m);
      wait_drain(200);

      // zero-error frame and read latency relative to err_last
      for (int k = 0; k < W; k++) begin f[k] = 32'hA5A5A5A5; m[k] = 32'h0; end
      send_data(f);
      send_err(m);
      check("lat_edge_n", out_valid, 0);
      @(posedge clk); #1;
      check("lat_edge_n1", out_valid, 0);
      @(posedge clk); #1;
      check("lat_edge_n2", out_valid, 1);
      wait_drain(200);
      check("proto_clean", proto_err, 0);

      // two full frames fill the buffer; in_ready returns after frame-0 out_last
      for (int k = 0; k < W; k++) begin f[k] = $urandom(); m[k] = 32'h0; end
      send_data(f);
      for (int k = 0; k < W; k++) f[k] = $urandom();
      send_data(f);
      check("full_in_ready", in_ready, 0);
      send_err(m);
      send_err(m);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk);
         if (out_valid && out_ready && out_last) seen = 1'b1;
         else n++;
      end
      if (!seen) fail_now("frame0_last_timeout");
      check("in_ready_before_free", in_ready, 0);
      @(posedge clk); #1;
      check("in_ready_after_free", in_ready, 1);
      wait_drain(200);

      // four random frames with random downstream stalls
      ready_rand = 1'b1;
      c0 = out_count;
      for (int fr = 0; fr < 4; fr++) begin
         for (int k = 0; k < W; k++) begin f[k] = $urandom(); m[k] = $urandom() & $urandom(); end
         send_data(f);
         send_err(m);
      end
      wait_drain(2000);
      ready_rand = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("out_count_4frames", out_count - c0, 32);

      // err_first with no data-complete frame, then a legal frame
      check("proto_before_illegal", proto_err, 0);
      for (int k = 0; k < W; k++) m[k] = 32'hFFFFFFFF;
      send_err(m);
      repeat (6) @(posedge clk);
      #1;
      check("no_out_after_illegal", out_valid, 0);
      for (int k = 0; k < W; k++) begin f[k] = $urandom(); m[k] = $urandom() & $urandom(); end
      send_data(f);
      send_err(m);
      wait_drain(200);
      check("proto_sticky", proto_err, 1);

      // reset while word 4 is on the output
      for (int k = 0; k < W; k++) begin f[k] = 32'h100 + k; m[k] = 32'h0; end
      send_data(f);
      send_err(m);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(negedge clk); #2;
         if (out_valid && out_data == 32'h104) seen = 1'b1;
         else n++;
      end
      if (!seen) fail_now("word4_timeout");
      reset = 1'b1;
      #1;
      check("rst_mid_out_valid", out_valid, 0);
      exp_q.delete();
      pend_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_in_ready", in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_in_ready_after", in_ready, 1);
      check("rst_mid_proto", proto_err, 0);
      for (int k = 0; k < W; k++) begin f[k] = $urandom(); m[k] = $urandom() & $urandom(); end
      send_data(f);
      send_err(m);
      wait_drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
